// File: rtl/uart_frame_feeder_pkg.sv
// Shared UART definitions: frame width and the feeder state encoding.
package uart_frame_feeder_pkg;

    localparam int FRAME_W = 24;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FIRE = 2'd1,
        ST_WAIT = 2'd2,
        ST_GAP  = 2'd3
    } feeder_state_e;

endpackage

// File: rtl/uart_frame_feeder_fifo.sv
// Single-clock synchronous FIFO; pointers carry an extra wrap bit so full and
// empty can be told apart when the indices match.
module frame_fifo #(
    parameter int W     = 24,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic [W-1:0] mem_q [DEPTH];
    logic         push_ok_s;
    logic         pop_ok_s;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rdata = mem_q[rd_ptr_q[AW-1:0]];

    // Next-pointer computation; overflowing pushes and underflowing pops are ignored.
    always_comb begin
        push_ok_s = push && !full;
        pop_ok_s  = pop && !empty;
        if (push_ok_s) begin
            wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok_s) begin
            rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

    // Pointer registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array; contents are only observed after a write, so no reset.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/uart_frame_feeder.sv
// Buffers producer frames and launches them one at a time into a UART frame
// transmitter, enforcing an idle gap and a completion timeout per frame.
module uart_frame_feeder
    import uart_frame_feeder_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int GAP_CYC     = 16,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [FRAME_W-1:0] din,
    input  logic               din_valid,
    output logic               din_ready,
    input  logic               err_clr,
    output logic               tx_enable,
    output logic [FRAME_W-1:0] tx_data,
    input  logic               tx_done,
    output logic               busy,
    output logic               timeout_err,
    output logic [7:0]         ovf_cnt
);

    localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam int TO_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
    localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
    localparam logic [TO_W-1:0]  TO_ONE   = TO_W'(1);

    feeder_state_e      state_q, state_d;
    logic [FRAME_W-1:0] tx_data_q, tx_data_d;
    logic               tx_enable_q, tx_enable_d;
    logic               tx_done_q, tx_done_d;
    logic               timeout_err_q, timeout_err_d;
    logic [7:0]         ovf_cnt_q, ovf_cnt_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic [TO_W-1:0]    to_cnt_q, to_cnt_d;

    logic               fifo_full_s;
    logic               fifo_empty_s;
    logic [FRAME_W-1:0] fifo_rdata_s;
    logic               push_s;
    logic               pop_s;
    logic               drop_s;
    logic               done_rise_s;
    logic               timeout_set_s;

    assign din_ready   = !fifo_full_s;
    assign push_s      = din_valid && !fifo_full_s;
    assign drop_s      = din_valid && fifo_full_s;
    assign done_rise_s = tx_done && !tx_done_q;

    assign tx_enable   = tx_enable_q;
    assign tx_data     = tx_data_q;
    assign timeout_err = timeout_err_q;
    assign ovf_cnt     = ovf_cnt_q;
    assign busy        = (state_q != ST_IDLE) || !fifo_empty_s;

    frame_fifo #(
        .W     (FRAME_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .pop   (pop_s),
        .wdata (din),
        .rdata (fifo_rdata_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // Launch sequencing FSM plus counter and status next-state logic.
    always_comb begin
        state_d       = state_q;
        tx_data_d     = tx_data_q;
        gap_cnt_d     = gap_cnt_q;
        to_cnt_d      = to_cnt_q;
        pop_s         = 1'b0;
        timeout_set_s = 1'b0;
        tx_done_d     = tx_done;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty_s) begin
                    pop_s     = 1'b1;
                    tx_data_d = fifo_rdata_s;
                    state_d   = ST_FIRE;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_FIRE: begin
                to_cnt_d = '0;
                state_d  = ST_WAIT;
            end
            // An edge seen during FIRE is absorbed by tx_done_q and never reaches here.
            ST_WAIT: begin
                if (done_rise_s) begin
                    gap_cnt_d = '0;
                    state_d   = ST_GAP;
                end else if (to_cnt_q == TO_LAST) begin
                    gap_cnt_d     = '0;
                    timeout_set_s = 1'b1;
                    state_d       = ST_GAP;
                end else begin
                    to_cnt_d = to_cnt_q + TO_ONE;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        tx_enable_d = (state_d == ST_FIRE);

        if (err_clr) begin
            timeout_err_d = 1'b0;
            ovf_cnt_d     = 8'd0;
        end else begin
            timeout_err_d = timeout_err_q || timeout_set_s;
            if (drop_s && (ovf_cnt_q != 8'hFF)) begin
                ovf_cnt_d = ovf_cnt_q + 8'd1;
            end else begin
                ovf_cnt_d = ovf_cnt_q;
            end
        end
    end

    // Feeder state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            tx_data_q     <= '0;
            tx_enable_q   <= 1'b0;
            tx_done_q     <= 1'b0;
            timeout_err_q <= 1'b0;
            ovf_cnt_q     <= 8'd0;
            gap_cnt_q     <= '0;
            to_cnt_q      <= '0;
        end else begin
            state_q       <= state_d;
            tx_data_q     <= tx_data_d;
            tx_enable_q   <= tx_enable_d;
            tx_done_q     <= tx_done_d;
            timeout_err_q <= timeout_err_d;
            ovf_cnt_q     <= ovf_cnt_d;
            gap_cnt_q     <= gap_cnt_d;
            to_cnt_q      <= to_cnt_d;
        end
    end

endmodule

// File: tb/tb_uart_frame_feeder.sv
// Directed self-checking bench for uart_frame_feeder with a launch scoreboard.
module tb_uart_frame_feeder;

    localparam int GAP = 16;
    localparam int TMO = 200;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] din;
    logic        din_valid;
    logic        din_ready;
    logic        err_clr;
    logic        tx_enable;
    logic [23:0] tx_data;
    logic        tx_done;
    logic        busy;
    logic        timeout_err;
    logic [7:0]  ovf_cnt;

    int          n_chk = 0;
    int          n_err = 0;
    int          cyc = 0;
    logic [23:0] sb [$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    uart_frame_feeder #(
        .DEPTH       (4),
        .GAP_CYC     (GAP),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .din         (din),
        .din_valid   (din_valid),
        .din_ready   (din_ready),
        .err_clr     (err_clr),
        .tx_enable   (tx_enable),
        .tx_data     (tx_data),
        .tx_done     (tx_done),
        .busy        (busy),
        .timeout_err (timeout_err),
        .ovf_cnt     (ovf_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive one word for one cycle; the expected acceptance is known from the scenario.
    task automatic push_word(input logic [23:0] w, input logic accept);
        check("din_ready_before_push", {31'd0, din_ready}, {31'd0, accept});
        din       = w;
        din_valid = 1'b1;
        if (accept) sb.push_back(w);
        step(1);
        din_valid = 1'b0;
    endtask

    task automatic wait_launch(input int limit, output int waited);
        waited = 0;
        while (waited < limit && tx_enable !== 1'b1) begin
            step(1);
            waited++;
        end
        check("launch_seen", {31'd0, tx_enable}, 32'd1);
    endtask

    task automatic wait_idle(input int limit, output int waited);
        waited = 0;
        while (waited < limit && busy !== 1'b0) begin
            step(1);
            waited++;
        end
        check("idle_reached", {31'd0, busy}, 32'd0);
    endtask

    task automatic check_launch_data(input string tag);
        logic [23:0] exp_w;
        exp_w = (sb.size() != 0) ? sb.pop_front() : 24'hDEAD00;
        check(tag, {8'd0, tx_data}, {8'd0, exp_w});
    endtask

    task automatic pulse_done();
        tx_done = 1'b1;
        step(1);
        tx_done = 1'b0;
    endtask

    initial begin
        int w;
        int last;
        int seen;

        rst       = 1'b0;
        din       = 24'd0;
        din_valid = 1'b0;
        err_clr   = 1'b0;
        tx_done   = 1'b0;

        // Reset state
        step(3);
        check("rst_tx_enable", {31'd0, tx_enable}, 32'd0);
        check("rst_tx_data", {8'd0, tx_data}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_timeout_err", {31'd0, timeout_err}, 32'd0);
        check("rst_ovf_cnt", {24'd0, ovf_cnt}, 32'd0);
        rst = 1'b1;
        step(1);
        check("rel_din_ready", {31'd0, din_ready}, 32'd1);

        // Single frame: exact latency, one-cycle pulse, exact gap length
        push_word(24'hA1B2C3, 1'b1);
        check("single_no_early_launch", {31'd0, tx_enable}, 32'd0);
        step(1);
        check("single_launch_2cyc", {31'd0, tx_enable}, 32'd1);
        check_launch_data("single_data");
        step(1);
        check("single_pulse_1cyc", {31'd0, tx_enable}, 32'd0);
        check("single_data_stable", {8'd0, tx_data}, 32'h00A1B2C3);
        pulse_done();
        check("single_busy_gap", {31'd0, busy}, 32'd1);
        step(GAP - 1);
        check("single_busy_gap_end", {31'd0, busy}, 32'd1);
        step(1);
        check("single_idle_after_gap", {31'd0, busy}, 32'd0);

        // Back-to-back words behind an in-flight frame: fifth word overflows
        push_word(24'h00000F, 1'b1);
        step(1);
        check("b2b_head_launch", {31'd0, tx_enable}, 32'd1);
        check_launch_data("b2b_head_data");
        last = cyc;
        for (int i = 1; i <= 5; i++) begin
            push_word(24'(i), (i <= 4) ? 1'b1 : 1'b0);
        end
        check("b2b_ovf_cnt", {24'd0, ovf_cnt}, 32'd1);
        pulse_done();
        for (int i = 0; i < 4; i++) begin
            wait_launch(200, w);
            check_launch_data("b2b_data");
            check("b2b_spacing", {31'd0, (cyc - last) >= (GAP + 1)}, 32'd1);
            last = cyc;
            step(50);
            pulse_done();
        end
        check("b2b_sb_empty", sb.size(), 32'd0);
        wait_idle(100, w);

        // tx_done already high before launch is not a completion
        tx_done = 1'b1;
        step(3);
        push_word(24'h123456, 1'b1);
        wait_launch(10, w);
        check_launch_data("held_data");
        step(30);
        check("held_no_completion", {31'd0, busy}, 32'd1);
        tx_done = 1'b0;
        step(3);
        pulse_done();
        wait_idle(40, w);
        check("held_gap_len", {31'd0, w >= GAP}, 32'd1);
        check("held_no_timeout", {31'd0, timeout_err}, 32'd0);

        // Timeout, with a tx_done pulse during FIRE that must be ignored
        push_word(24'h0BAD01, 1'b1);
        push_word(24'h0BAD02, 1'b1);
        check("tmo_launch", {31'd0, tx_enable}, 32'd1);
        check_launch_data("tmo_data1");
        pulse_done();
        seen = 1;
        while (seen < TMO + 10 && timeout_err !== 1'b1) begin
            step(1);
            seen++;
        end
        check("tmo_cycles", seen, TMO + 1);
        wait_launch(GAP + 5, w);
        check_launch_data("tmo_next_data");
        err_clr = 1'b1;
        step(1);
        err_clr = 1'b0;
        check("clr_timeout_err", {31'd0, timeout_err}, 32'd0);
        check("clr_ovf_cnt", {24'd0, ovf_cnt}, 32'd0);

        // Asynchronous reset while in WAIT with three frames queued
        push_word(24'h0000C1, 1'b1);
        push_word(24'h0000C2, 1'b1);
        push_word(24'h0000C3, 1'b1);
        rst = 1'b0;
        #1;
        check("mid_rst_tx_enable", {31'd0, tx_enable}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        sb.delete();
        step(2);
        rst = 1'b1;
        step(1);
        check("mid_rel_din_ready", {31'd0, din_ready}, 32'd1);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (tx_enable === 1'b1) seen++;
            step(1);
        end
        check("mid_no_launch", seen, 32'd0);
        push_word(24'h5A5A5A, 1'b1);
        step(1);
        check("mid_new_launch", {31'd0, tx_enable}, 32'd1);
        check_launch_data("mid_new_data");

        // Overflow saturation, then err_clr beats a same-cycle overflow
        din_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            din = 24'(i);
            step(1);
        end
        check("sat_ovf_cnt", {24'd0, ovf_cnt}, 32'd255);
        check("sat_timeout_err", {31'd0, timeout_err}, 32'd1);
        err_clr = 1'b1;
        step(1);
        err_clr   = 1'b0;
        din_valid = 1'b0;
        check("clr_prio_ovf", {24'd0, ovf_cnt}, 32'd0);
        check("clr_prio_tmo", {31'd0, timeout_err}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
